alu_ft_retry: RTL and testbench

- Parametrised-width successor to the 16-bit fault-tolerant ALU.
- Same opcode set and the same four concurrent checkers: parity prediction, mod-3 residue, mod-5 residue and duplicated carry chain.
- Adds a valid/ready handshake, a registered result and a retry state machine that re-executes an arithmetic operation when a checker fires.
- Provides per-transaction status (retried/fatal), a saturating error counter and a fault-injection hook for verification.

---
 rtl/alu_ft_retry.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_ft_retry.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ft_retry.sv
// Parametrised fault-tolerant ALU: parity, mod-3, mod-5 and duplicated-carry checkers
// around a shared adder, wrapped in a valid/ready FSM that re-executes on a detected error.
module alu_ft_retry #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] fault_mask,
  input  logic             fault_persist,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic [3:0]       err_flags,
  output logic             retried,
  output logic             fatal,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned  AW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [AW-1:0] MAX_ATT = AW'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR  = 4'd7,
    OP_INC  = 4'd8,  OP_DEC = 4'd9, OP_PASS = 4'd10, OP_ZERO = 4'd11
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mask_q, mask_d;
  logic [3:0]       op_q, op_d;
  logic             persist_q, persist_d;
  logic [AW-1:0]    attempt_q, attempt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [3:0]       flags_q, flags_d;
  logic             retried_q, retried_d, fatal_q, fatal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             arith, cin, c_out;
  logic [WIDTH-1:0] b_eff, mask_eff, sum_raw, sum_m, alu_res;
  logic [WIDTH:0]   carry_p, carry_d;
  logic             chk_parity, chk_res3, chk_res5, chk_carry, alu_ovf, err_any;
  logic [3:0]       alu_flags;

  // Residue of v modulo m (m <= 5), folded MSB-first so no wide divider is needed.
  function automatic logic [2:0] residue(input logic [WIDTH:0] v, input logic [2:0] m);
    logic [WIDTH:0] sh;
    logic [3:0]     r;
    sh = v;
    r  = '0;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      r = {r[2:0], sh[WIDTH]};
      if (r >= {1'b0, m}) r = r - {1'b0, m};
      sh = sh << 1;
    end
    return r[2:0];
  endfunction

  function automatic logic [2:0] mod_small(input logic [3:0] x, input logic [2:0] m);
    logic [3:0] y;
    y = x;
    if (y >= {1'b0, m}) y = y - {1'b0, m};
    if (y >= {1'b0, m}) y = y - {1'b0, m};
    return y[2:0];
  endfunction

  always_comb begin
    logic cp, cd;
    arith = 1'b0;
    b_eff = b_q;
    cin   = 1'b0;
    case (op_q)
      OP_ADD: arith = 1'b1;
      OP_SUB: begin arith = 1'b1; b_eff = ~b_q; cin = 1'b1; end
      OP_INC: begin arith = 1'b1; b_eff = '0;   cin = 1'b1; end
      OP_DEC: begin arith = 1'b1; b_eff = '1;   end
      default: ;
    endcase

    mask_eff = (persist_q || attempt_q == '0) ? mask_q : '0;

    // Primary chain in generate/propagate form, duplicate as a majority function.
    cp = cin;
    cd = cin;
    sum_raw = '0;
    carry_p = '0;
    carry_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry_p[i] = cp;
      carry_d[i] = cd;
      sum_raw[i] = a_q[i] ^ b_eff[i] ^ cp;
      cp = (a_q[i] & b_eff[i]) | (cp & (a_q[i] ^ b_eff[i]));
      cd = (a_q[i] & b_eff[i]) | (a_q[i] & cd) | (b_eff[i] & cd);
    end
    carry_p[WIDTH] = cp;
    carry_d[WIDTH] = cd;

    sum_m = sum_raw ^ mask_eff;
    c_out = carry_p[WIDTH];

    chk_parity = (^a_q) ^ (^b_eff) ^ (^carry_p[WIDTH-1:0]) ^ (^sum_m);
    chk_res3   = mod_small({1'b0, residue({1'b0, a_q}, 3'd3)} + {1'b0, residue({1'b0, b_eff}, 3'd3)}
                           + {3'b0, cin}, 3'd3) != residue({c_out, sum_m}, 3'd3);
    chk_res5   = mod_small({1'b0, residue({1'b0, a_q}, 3'd5)} + {1'b0, residue({1'b0, b_eff}, 3'd5)}
                           + {3'b0, cin}, 3'd5) != residue({c_out, sum_m}, 3'd5);
    chk_carry  = carry_p != carry_d;

    alu_flags = arith ? {chk_carry, chk_res5, chk_res3, chk_parity} : '0;
    err_any   = |alu_flags;
    alu_ovf   = arith & (a_q[WIDTH-1] == b_eff[WIDTH-1]) & (sum_m[WIDTH-1] != a_q[WIDTH-1]);

    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: alu_res = sum_m;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SHL:  alu_res = {a_q[WIDTH-2:0], 1'b0};
      OP_SHR:  alu_res = {1'b0, a_q[WIDTH-1:1]};
      OP_PASS: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mask_d    = mask_q;
    op_d      = op_q;
    persist_d = persist_q;
    attempt_d = attempt_q;
    result_d  = result_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    flags_d   = flags_q;
    retried_d = retried_q;
    fatal_d   = fatal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_EXEC;
          a_d       = operand_a;
          b_d       = operand_b;
          op_d      = alu_opcode;
          mask_d    = fault_mask;
          persist_d = fault_persist;
          attempt_d = '0;
        end
      end
      S_EXEC: begin
        result_d  = alu_res;
        cout_d    = arith & c_out;
        zero_d    = (alu_res == '0);
        ovf_d     = alu_ovf;
        flags_d   = alu_flags;
        retried_d = (attempt_q != '0);
        fatal_d   = err_any;
        if (err_any && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (err_any && attempt_q < MAX_ATT) attempt_d = attempt_q + AW'(1);
        else                                state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mask_q    <= '0;
      op_q      <= '0;
      persist_q <= 1'b0;
      attempt_q <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      flags_q   <= '0;
      retried_q <= 1'b0;
      fatal_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mask_q    <= mask_d;
      op_q      <= op_d;
      persist_q <= persist_d;
      attempt_q <= attempt_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      flags_q   <= flags_d;
      retried_q <= retried_d;
      fatal_q   <= fatal_d;
      cnt_q     <= cnt_d;
    end
  end

  // in_ready is held low while rst_n is asserted even though the state is already IDLE.
  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign err_flags = flags_q;
  assign retried   = retried_q;
  assign fatal     = fatal_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_alu_ft_retry.sv
// Bench for alu_ft_retry (WIDTH=32, MAX_RETRY=2): vector table, random model check,
// back-pressure and reset-abandon sequences, with expected results queued per request.
module tb_alu_ft_retry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [3:0]  alu_opcode = '0;
  logic [31:0] fault_mask = '0;
  logic        fault_persist = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        cout, zero, overflow;
  logic [3:0]  err_flags;
  logic        retried, fatal;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  alu_ft_retry #(.WIDTH(32), .MAX_RETRY(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_opcode(alu_opcode),
    .fault_mask(fault_mask), .fault_persist(fault_persist),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout),
    .zero(zero), .overflow(overflow), .err_flags(err_flags), .retried(retried),
    .fatal(fatal), .err_count(err_count)
  );

  typedef struct {
    logic        pre_rst;
    logic [3:0]  op;
    logic [31:0] a, b, mask;
    logic        persist;
    logic [31:0] res;
    logic        cout, zero, ovf;
    logic [3:0]  flags;
    logic        retried, fatal;
    int          lat;
    int          cnt_inc;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[25];
  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic pr, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] mask, logic persist, logic [31:0] res,
                              logic c, logic z, logic v, logic [3:0] fl,
                              logic rt, logic ft, int lat, int cnt);
    vec_t t;
    t.pre_rst = pr; t.op = op; t.a = a; t.b = b; t.mask = mask; t.persist = persist;
    t.res = res; t.cout = c; t.zero = z; t.ovf = v; t.flags = fl;
    t.retried = rt; t.fatal = ft; t.lat = lat; t.cnt_inc = cnt;
    return t;
  endfunction

  // Independent reference using native 33-bit arithmetic; fault-free expectations only.
  function automatic vec_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] mask, logic persist);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  begin s = {1'b0, a} + {1'b0, b};        r = s[31:0]; c = s[32];
                   v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1:  begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                   v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  r = a << 1;
      4'd7:  r = a >> 1;
      4'd8:  begin s = {1'b0, a} + 33'd1; r = s[31:0]; c = s[32]; v = (a == 32'h7FFFFFFF); end
      4'd9:  begin s = {1'b0, a} + 33'h0FFFFFFFF; r = s[31:0]; c = s[32]; v = (a == 32'h80000000); end
      4'd10: r = a;
      default: r = '0;
    endcase
    return mk(1'b0, op, a, b, mask, persist, r, c, (r == 32'h0), v, 4'h0, 1'b0, 1'b0, 2, 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_err_count", {24'h0, err_count}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Drives a request and returns in the cycle after the accept edge, with inputs scrambled.
  task automatic start_txn(input vec_t v);
    int t;
    exp_q.push_back(v);
    @(negedge clk);
    in_valid = 1'b1; operand_a = v.a; operand_b = v.b; alu_opcode = v.op;
    fault_mask = v.mask; fault_persist = v.persist;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) chk("accept_timeout", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    operand_a = $urandom; operand_b = $urandom; alu_opcode = 4'($urandom_range(0, 15));
    fault_mask = $urandom; fault_persist = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result();
    int   lat;
    vec_t e;
    lat = 1;
    while (!out_valid && lat < 12) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    if (!out_valid) begin
      chk("out_valid_timeout", {31'h0, out_valid}, 32'h1);
    end else begin
      exp_cnt += e.cnt_inc;
      chk("result",    result, e.res);
      chk("cout",      {31'h0, cout}, {31'h0, e.cout});
      chk("zero",      {31'h0, zero}, {31'h0, e.zero});
      chk("overflow",  {31'h0, overflow}, {31'h0, e.ovf});
      chk("err_flags", {28'h0, err_flags}, {28'h0, e.flags});
      chk("retried",   {31'h0, retried}, {31'h0, e.retried});
      chk("fatal",     {31'h0, fatal}, {31'h0, e.fatal});
      chk("latency",   lat, e.lat);
      chk("err_count", {24'h0, err_count}, exp_cnt);
      chk("in_ready_done", {31'h0, in_ready}, 32'h0);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", {31'h0, out_valid}, 32'h0);
    chk("post_in_ready",  {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    vec_t bp, nx, rv;

    #3;
    chk("reset_in_ready",  {31'h0, in_ready}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_result",    result, 32'h0);
    chk("reset_flags",     {24'h0, err_flags, cout, zero, overflow, fatal}, 32'h0);
    chk("reset_retried",   {31'h0, retried}, 32'h0);
    chk("reset_err_count", {24'h0, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", {31'h0, in_ready}, 32'h1);

    //          pr  op     a             b             mask          p   res           c  z  v  flags  rt ft lat cnt
    tbl[0]  = mk(0, 4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 32'h00000000, 1, 1, 0, 4'h0, 0, 0, 2, 0);
    tbl[1]  = mk(0, 4'h1, 32'h00000005, 32'h00000003, 32'h0,        0, 32'h00000002, 1, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[2]  = mk(0, 4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h0,        0, 32'h80000000, 0, 0, 1, 4'h0, 0, 0, 2, 0);
    tbl[3]  = mk(0, 4'h1, 32'h00000003, 32'h00000005, 32'h0,        0, 32'hFFFFFFFE, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[4]  = mk(0, 4'h1, 32'h80000000, 32'h00000001, 32'h0,        0, 32'h7FFFFFFF, 1, 0, 1, 4'h0, 0, 0, 2, 0);
    tbl[5]  = mk(0, 4'h8, 32'hFFFFFFFF, 32'h00001234, 32'h0,        0, 32'h00000000, 1, 1, 0, 4'h0, 0, 0, 2, 0);
    tbl[6]  = mk(0, 4'h9, 32'h00000000, 32'h00000000, 32'h0,        0, 32'hFFFFFFFF, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[7]  = mk(0, 4'h9, 32'h80000000, 32'h00000000, 32'h0,        0, 32'h7FFFFFFF, 1, 0, 1, 4'h0, 0, 0, 2, 0);
    tbl[8]  = mk(0, 4'h2, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1, 32'h00000000, 0, 1, 0, 4'h0, 0, 0, 2, 0);
    tbl[9]  = mk(0, 4'h3, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0,        0, 32'hFFFFF0F0, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[10] = mk(0, 4'h4, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        0, 32'hF0F00F0F, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[11] = mk(0, 4'h5, 32'h12345678, 32'h0,        32'h0,        0, 32'hEDCBA987, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[12] = mk(0, 4'h6, 32'h80000001, 32'h0,        32'h0,        0, 32'h00000002, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[13] = mk(0, 4'h7, 32'h80000001, 32'h0,        32'h0,        0, 32'h40000000, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[14] = mk(0, 4'hA, 32'hDEADBEEF, 32'h1,        32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    tbl[15] = mk(0, 4'hB, 32'h00000005, 32'h7,        32'h0,        0, 32'h00000000, 0, 1, 0, 4'h0, 0, 0, 2, 0);
    tbl[16] = mk(0, 4'hC, 32'h0000FFFF, 32'hFFFF,     32'h0,        0, 32'h00000000, 0, 1, 0, 4'h0, 0, 0, 2, 0);
    tbl[17] = mk(0, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF,       1, 32'h00000000, 0, 1, 0, 4'h0, 0, 0, 2, 0);
    tbl[18] = mk(0, 4'h0, 32'h12345678, 32'h11111111, 32'h1,        0, 32'h23456789, 0, 0, 0, 4'h0, 1, 0, 3, 1);
    tbl[19] = mk(1, 4'h0, 32'h12345678, 32'h11111111, 32'h1,        1, 32'h23456788, 0, 0, 0, 4'h7, 1, 1, 4, 3);
    tbl[20] = mk(0, 4'h0, 32'h12345678, 32'h11111111, 32'h3,        1, 32'h2345678A, 0, 0, 0, 4'h6, 1, 1, 4, 3);
    tbl[21] = mk(0, 4'h0, 32'h12345678, 32'h11111111, 32'h5,        1, 32'h2345678C, 0, 0, 0, 4'h4, 1, 1, 4, 3);
    tbl[22] = mk(0, 4'h0, 32'h12345678, 32'h11111111, 32'h7,        1, 32'h2345678E, 0, 0, 0, 4'h3, 1, 1, 4, 3);
    tbl[23] = mk(0, 4'h1, 32'h00000005, 32'h00000003, 32'h1,        0, 32'h00000002, 1, 0, 0, 4'h0, 1, 0, 3, 1);
    tbl[24] = mk(0, 4'h4, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h1,        0, 32'hFFFFFFFF, 0, 0, 0, 4'h0, 0, 0, 2, 0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      start_txn(tbl[i]);
      wait_result();
      release_out();
    end

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b, m;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      m  = (op inside {4'd0, 4'd1, 4'd8, 4'd9}) ? 32'h0 : $urandom;
      if (i == 0) a = 32'h7FFFFFFF;
      rv = model(op, a, b, m, 1'($urandom_range(0, 1)));
      start_txn(rv);
      wait_result();
      release_out();
    end

    // Back-pressure: result held for 5 cycles while a new request waits on in_valid.
    bp = mk(0, 4'h3, 32'h0000FFFF, 32'hFF000000, 32'h0, 0, 32'hFF00FFFF, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    nx = mk(0, 4'h0, 32'h00000001, 32'h00000002, 32'h0, 0, 32'h00000003, 0, 0, 0, 4'h0, 0, 0, 2, 0);
    start_txn(bp);
    wait_result();
    in_valid = 1'b1; operand_a = nx.a; operand_b = nx.b; alu_opcode = nx.op;
    fault_mask = '0; fault_persist = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_in_ready",  {31'h0, in_ready}, 32'h0);
      chk("bp_result",    result, bp.res);
      chk("bp_status",    {27'h0, err_flags, zero}, 32'h0);
    end
    out_ready = 1'b1;
    exp_q.push_back(nx);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_out_valid", {31'h0, out_valid}, 32'h0);
    chk("bp_release_in_ready",  {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result();
    release_out();

    // Reset in the middle of a persistently-faulted retry loop.
    do_reset();
    rv = mk(0, 4'h0, 32'h12345678, 32'h11111111, 32'h1, 1, 32'h0, 0, 0, 0, 4'h0, 0, 0, 4, 3);
    start_txn(rv);
    @(negedge clk);
    chk("mid_exec_err_count", {24'h0, err_count}, 32'h1);
    chk("mid_exec_out_valid", {31'h0, out_valid}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    chk("abort_outputs", {result[31:1], out_valid}, 32'h0);
    chk("abort_status",  {20'h0, err_flags, cout, zero, overflow, retried, fatal, in_ready, 2'b00}, 32'h0);
    chk("abort_result",  result, 32'h0);
    chk("abort_err_count", {24'h0, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'h0, out_valid}, 32'h0);
    end
    chk("abort_final_count", {24'h0, err_count}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
